starforc_color_mixer: RTL and testbench

//  Pixel back end downstream of starforc_board2. Takes the char pixel (SC/SV), sprite pixel (OC/OV),
//  two scroll-BG pixels and the composite blank/sync, resolves layer priority, looks up a 512x8
//  CPU-writable palette RAM and emits 4:4:4 RGB with matching delayed syncs.

---
 rtl/starforc_color_mixer.sv | 159 +++++++++++++++
 tb/tb_starforc_color_mixer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/starforc_color_mixer.sv
// Pixel back end: latches the layer pixels, resolves priority into a palette
// address, and turns the palette byte into 4:4:4 RGB with syncs delayed to match.
// Also handles CPU palette access through a one-entry write buffer that drains
// only on clocks when the pixel path is not reading the RAM.
module starforc_color_mixer #(
  parameter int PIPE_DLY = 3,
  parameter int PAL_AW   = 9
) (
  input  logic              clk48m,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic [2:0]        SC,
  input  logic [2:0]        SV,
  input  logic [4:0]        OC,
  input  logic [2:0]        OV,
  input  logic [2:0]        B1C,
  input  logic [2:0]        B1V,
  input  logic [2:0]        B2C,
  input  logic [2:0]        B2V,
  input  logic              pri_sel,
  input  logic              nCMPBLK,
  input  logic              nHSYNC,
  input  logic              nVSYNC,
  input  logic              nCS_PAL,
  input  logic              nMEWR,
  input  logic              nMERD,
  input  logic [PAL_AW-1:0] CPU_A,
  input  logic [7:0]        DCON_in,
  output logic [7:0]        DCON_out,
  output logic [3:0]        R,
  output logic [3:0]        G,
  output logic [3:0]        B,
  output logic              oHSYNC,
  output logic              oVSYNC,
  output logic              oBLANK,
  output logic              wr_busy
);

  typedef struct packed {
    logic [2:0] sc;
    logic [2:0] sv;
    logic [4:0] oc;
    logic [2:0] ov;
    logic [2:0] b1c;
    logic [2:0] b1v;
    logic [2:0] b2c;
    logic [2:0] b2v;
    logic       pri;
  } pix_t;

  typedef struct packed {
    logic blank_n;
    logic hs_n;
    logic vs_n;
  } ctl_t;

  // palette byte IIBBGGRR -> {R1R0 I1I0, G1G0 I1I0, B1B0 I1I0}
  function automatic logic [11:0] pal_to_rgb(input logic [7:0] d);
    return {d[1:0], d[7:6], d[3:2], d[7:6], d[5:4], d[7:6]};
  endfunction

  logic [7:0]              pal [2**PAL_AW];
  pix_t                    s1;
  ctl_t [PIPE_DLY-1:0]     ctl_pipe;
  logic [PAL_AW-1:0]       pix_addr, addr2;
  logic [11:0]             rgb;

  logic [2:0]              wsync, rsync;
  logic                    wfall, rfall;
  logic                    busy, commit, rd_pend;
  logic [PAL_AW-1:0]       wa;
  logic [7:0]              wd, rd_data;

  // Stage 1: capture layer inputs and priority mode for this pixel
  always_ff @(posedge clk48m or posedge reset)
    if (reset)       s1 <= '0;
    else if (pix_ce) s1 <= {SC, SV, OC, OV, B1C, B1V, B2C, B2V, pri_sel};

  // Blank/sync delay line, one slot per pipeline stage
  always_ff @(posedge clk48m or posedge reset)
    if (reset)       ctl_pipe <= '1;
    else if (pix_ce) ctl_pipe <= {ctl_pipe[PIPE_DLY-2:0], ctl_t'{nCMPBLK, nHSYNC, nVSYNC}};

  // Priority resolve: pri_sel only swaps char and sprite, BGs always trail
  always_comb begin
    pix_addr = '0;
    if (!s1.pri && s1.sv != 3'd0)  pix_addr = {3'b000, s1.sc, s1.sv};
    else if (s1.ov != 3'd0)        pix_addr = {1'b1, s1.oc, s1.ov};
    else if (s1.sv != 3'd0)        pix_addr = {3'b000, s1.sc, s1.sv};
    else if (s1.b1v != 3'd0)       pix_addr = {3'b010, s1.b1c, s1.b1v};
    else if (s1.b2v != 3'd0)       pix_addr = {3'b011, s1.b2c, s1.b2v};
  end

  // Stage 2: register the winning palette address
  always_ff @(posedge clk48m or posedge reset)
    if (reset)       addr2 <= '0;
    else if (pix_ce) addr2 <= pix_addr;

  // Stage 3: palette lookup and colour expansion, blanked when nCMPBLK was low
  always_ff @(posedge clk48m or posedge reset)
    if (reset)       rgb <= '0;
    else if (pix_ce) rgb <= ctl_pipe[1].blank_n ? pal_to_rgb(pal[addr2]) : 12'd0;

  assign {R, G, B}                = rgb;
  assign {oBLANK, oHSYNC, oVSYNC} = ctl_pipe[PIPE_DLY-1];

  // CPU strobes are asynchronous: two sync flops plus one for edge detect
  always_ff @(posedge clk48m or posedge reset)
    if (reset) begin
      wsync <= '1;
      rsync <= '1;
    end else begin
      wsync <= {wsync[1:0], nCS_PAL | nMEWR};
      rsync <= {rsync[1:0], nCS_PAL | nMERD};
    end

  assign wfall  = wsync[2] & ~wsync[1];
  assign rfall  = rsync[2] & ~rsync[1];
  // Pixel reads own the RAM on pix_ce clocks. Synced edges are at least two
  // clocks apart and pix_ce never fires twice in a row, so a held entry always
  // drains no later than the clock that latches the next one.
  assign commit = busy & ~pix_ce;

  // One-entry write buffer
  always_ff @(posedge clk48m or posedge reset)
    if (reset) begin
      busy <= 1'b0;
      wa   <= '0;
      wd   <= '0;
    end else begin
      if (commit) busy <= 1'b0;
      if (wfall) begin
        busy <= 1'b1;
        wa   <= CPU_A;
        wd   <= DCON_in;
      end
    end

  // Palette RAM write port (contents survive reset)
  always_ff @(posedge clk48m)
    if (commit) pal[wa] <= wd;

  // CPU read on a free clock; a pending write to the same address wins
  always_ff @(posedge clk48m or posedge reset)
    if (reset) begin
      rd_pend <= 1'b0;
      rd_data <= '0;
    end else begin
      if (rd_pend && !pix_ce) begin
        rd_pend <= 1'b0;
        rd_data <= (busy && wa == CPU_A) ? wd : pal[CPU_A];
      end
      if (rfall) rd_pend <= 1'b1;
    end

  assign DCON_out = (!nCS_PAL && !nMERD) ? rd_data : 8'd0;
  assign wr_busy  = busy;

endmodule

// File: tb/tb_starforc_color_mixer.sv
// Bench for starforc_color_mixer: a queue-based pixel model checked every clock,
// CPU palette traffic against a shadow palette, plus literal spot checks.
module tb_starforc_color_mixer;

  logic       clk48m = 0, reset = 0, pix_ce = 0;
  logic [2:0] SC = 0, SV = 0, OV = 0, B1C = 0, B1V = 0, B2C = 0, B2V = 0;
  logic [4:0] OC = 0;
  logic       pri_sel = 0, nCMPBLK = 1, nHSYNC = 1, nVSYNC = 1;
  logic       nCS_PAL = 1, nMEWR = 1, nMERD = 1;
  logic [8:0] CPU_A = 0;
  logic [7:0] DCON_in = 0;
  logic [7:0] DCON_out;
  logic [3:0] R, G, B;
  logic       oHSYNC, oVSYNC, oBLANK, wr_busy;

  starforc_color_mixer dut (
    .clk48m(clk48m), .reset(reset), .pix_ce(pix_ce),
    .SC(SC), .SV(SV), .OC(OC), .OV(OV), .B1C(B1C), .B1V(B1V), .B2C(B2C), .B2V(B2V),
    .pri_sel(pri_sel), .nCMPBLK(nCMPBLK), .nHSYNC(nHSYNC), .nVSYNC(nVSYNC),
    .nCS_PAL(nCS_PAL), .nMEWR(nMEWR), .nMERD(nMERD), .CPU_A(CPU_A), .DCON_in(DCON_in),
    .DCON_out(DCON_out), .R(R), .G(G), .B(B),
    .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oBLANK(oBLANK), .wr_busy(wr_busy)
  );

  always #5 clk48m = ~clk48m;

  // 6 MHz pixel enable: one clock high out of eight, changed away from posedge
  int phase = 0;
  always @(negedge clk48m) begin
    phase  = (phase + 1) % 8;
    pix_ce = (phase == 0);
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [2:0] sc, sv; logic [4:0] oc; logic [2:0] ov, b1c, b1v, b2c, b2v;
    logic pri, blk, hs, vs;
  } rec_t;

  rec_t       q[$];
  logic [7:0] pal_m [512];
  logic [3:0] er = 0, eg = 0, eb = 0;
  logic       ehs = 1, evs = 1, eblk = 1;
  bit         exp_ok = 0, chk_en = 0, rnd_on = 0;

  function automatic rec_t backdrop();
    rec_t r;
    r.sc = 0; r.sv = 0; r.oc = 0; r.ov = 0; r.b1c = 0; r.b1v = 0; r.b2c = 0; r.b2v = 0;
    r.pri = 0; r.blk = 1; r.hs = 1; r.vs = 1;
    return r;
  endfunction

  // topmost opaque layer wins; pri swaps char and sprite only
  function automatic logic [8:0] model_addr(input rec_t r);
    bit c = (r.sv != 0), s = (r.ov != 0);
    if (!r.pri && c) return {3'b000, r.sc, r.sv};
    if (s)           return {1'b1, r.oc, r.ov};
    if (c)           return {3'b000, r.sc, r.sv};
    if (r.b1v != 0)  return {3'b010, r.b1c, r.b1v};
    if (r.b2v != 0)  return {3'b011, r.b2c, r.b2v};
    return 9'h000;
  endfunction

  // pixel sampled two enables ago is what the current enable puts on the pins
  always @(posedge clk48m or posedge reset) begin : model
    rec_t cur, old;
    int   di, ii;
    if (reset) begin
      q = {};
      q.push_back(backdrop());
      q.push_back(backdrop());
      er = 0; eg = 0; eb = 0; ehs = 1; evs = 1; eblk = 1;
      exp_ok = chk_en;
    end else if (pix_ce) begin
      cur.sc = SC; cur.sv = SV; cur.oc = OC; cur.ov = OV; cur.b1c = B1C; cur.b1v = B1V;
      cur.b2c = B2C; cur.b2v = B2V; cur.pri = pri_sel; cur.blk = nCMPBLK;
      cur.hs = nHSYNC; cur.vs = nVSYNC;
      q.push_back(cur);
      old = q.pop_front();
      di  = int'(pal_m[model_addr(old)]);
      ii  = di / 64;
      if (old.blk) begin
        er = 4'((di % 4) * 4 + ii);
        eg = 4'(((di / 4) % 4) * 4 + ii);
        eb = 4'(((di / 16) % 4) * 4 + ii);
      end else begin
        er = 0; eg = 0; eb = 0;
      end
      ehs = old.hs; evs = old.vs; eblk = old.blk;
      exp_ok = chk_en;
    end
  end

  // every-cycle compare, away from the active edge
  always @(negedge clk48m) begin
    if (exp_ok) begin
      chk("R", R, er);
      chk("G", G, eg);
      chk("B", B, eb);
      chk("oHSYNC", oHSYNC, ehs);
      chk("oVSYNC", oVSYNC, evs);
      chk("oBLANK", oBLANK, eblk);
    end
    if (nCS_PAL | nMERD) chk("dcon_idle", DCON_out, 8'h00);
  end

  // random pixel stream, driven just after each enable
  always @(posedge clk48m)
    if (pix_ce && rnd_on) begin
      #1;
      SC  = 3'($urandom); SV  = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0;
      OC  = 5'($urandom); OV  = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0;
      B1C = 3'($urandom); B1V = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'd0;
      B2C = 3'($urandom); B2V = 3'($urandom);
      pri_sel = 1'($urandom);
      nCMPBLK = ($urandom_range(0, 7) != 0);
      nHSYNC  = 1'($urandom);
      nVSYNC  = 1'($urandom);
    end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk48m);
    #1;
  endtask

  task automatic wait_pix();
    do @(posedge clk48m); while (!pix_ce);
    #1;
  endtask

  task automatic set_pix(input logic [2:0] sc, sv, input logic [4:0] oc, input logic [2:0] ov,
                         input logic pri, blk);
    SC = sc; SV = sv; OC = oc; OV = ov; B1C = 0; B1V = 0; B2C = 0; B2V = 0;
    pri_sel = pri; nCMPBLK = blk; nHSYNC = 1; nVSYNC = 1;
  endtask

  // strobe low 4 clks, high 4 clks; shadow updated up front
  task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
    CPU_A = a; DCON_in = d; pal_m[a] = d;
    nCS_PAL = 0; nMEWR = 0;
    tick(4);
    nMEWR = 1; nCS_PAL = 1;
    tick(4);
  endtask

  task automatic cpu_rd(input logic [8:0] a);
    CPU_A = a; nCS_PAL = 0; nMERD = 0;
    tick(8);
    chk("cpu_rd", DCON_out, pal_m[a]);
    nMERD = 1; nCS_PAL = 1;
    #1 chk("rd_release", DCON_out, 8'h00);
    tick(3);
  endtask

  task automatic chk_rgb(input string name, input logic [11:0] exp);
    chk(name, {R, G, B}, exp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    #2 reset = 1;
    #1;
    chk("rst_rgb", {R, G, B}, 12'h000);
    chk("rst_sync", {oHSYNC, oVSYNC, oBLANK}, 3'b111);
    chk("rst_busy", wr_busy, 1'b0);
    chk("rst_dcon", DCON_out, 8'h00);
    tick(3);
    reset = 0;

    // fill the whole palette so every pixel is defined
    wait_pix();
    for (int a = 0; a < 512; a++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if (a == 9'h000) d = 8'h24;
      if (a == 9'h01A) d = 8'h81;
      if (a == 9'h115) d = 8'h3C;
      if (a == 9'h1FF) d = 8'h00;
      cpu_wr(9'(a), d);
    end
    chk_en = 1;
    wait_pix();
    wait_pix();
    chk_rgb("backdrop", 12'h048);

    // sprite at 0x1FF after writing C3, three-enable latency
    wait_pix();
    cpu_wr(9'h1FF, 8'hC3);
    wait_pix();
    set_pix(0, 0, 5'h1F, 3'd7, 0, 1);
    wait_pix();
    wait_pix();
    chk_rgb("lat_old", 12'h048);
    wait_pix();
    chk_rgb("spr_1ff", 12'hF33);

    // char vs sprite priority
    set_pix(3'd3, 3'd2, 5'h02, 3'd5, 0, 1);
    wait_pix(); wait_pix(); wait_pix();
    chk_rgb("pri0_char", 12'h622);
    pri_sel = 1;
    wait_pix(); wait_pix(); wait_pix();
    chk_rgb("pri1_spr", 12'h0CC);

    // all transparent, then blank alignment
    set_pix(0, 0, 0, 0, 0, 1);
    wait_pix(); wait_pix(); wait_pix();
    chk_rgb("all_clear", 12'h048);
    nCMPBLK = 0;
    wait_pix(); wait_pix();
    chk("blank_early", oBLANK, 1'b1);
    chk_rgb("blank_early_rgb", 12'h048);
    wait_pix();
    chk("blank_on", oBLANK, 1'b0);
    chk_rgb("blank_rgb", 12'h000);
    nCMPBLK = 1;

    // write edge landing on a pix_ce clock: commit deferred one clock
    wait_pix();
    tick(4);
    CPU_A = 9'h1FF; DCON_in = 8'h5A; pal_m[9'h1FF] = 8'h5A;
    nCS_PAL = 0; nMEWR = 0;
    tick(3);
    chk("busy_set", wr_busy, 1'b1);
    tick(1);
    chk("busy_hold_pix", wr_busy, 1'b1);
    tick(1);
    chk("busy_clear_late", wr_busy, 1'b0);
    nMEWR = 1; nCS_PAL = 1;
    tick(3);
    // normal case: commit on the clock after latching
    wait_pix();
    CPU_A = 9'h100; DCON_in = 8'h77; pal_m[9'h100] = 8'h77;
    nCS_PAL = 0; nMEWR = 0;
    tick(3);
    chk("busy_set2", wr_busy, 1'b1);
    tick(1);
    chk("busy_clear", wr_busy, 1'b0);
    nMEWR = 1; nCS_PAL = 1;
    tick(3);
    wait_pix();
    cpu_rd(9'h1FF);
    wait_pix();
    cpu_rd(9'h100);

    // reset mid-frame with a write latched but not committed
    set_pix(0, 0, 5'h02, 3'd5, 1, 1);
    wait_pix();
    CPU_A = 9'h0AA; DCON_in = ~pal_m[9'h0AA];
    nCS_PAL = 0; nMEWR = 0;
    tick(3);
    chk("busy_before_rst", wr_busy, 1'b1);
    #2 reset = 1;
    nMEWR = 1; nCS_PAL = 1;
    #1;
    chk_rgb("rst_mid_rgb", 12'h000);
    chk("rst_mid_sync", {oHSYNC, oVSYNC, oBLANK}, 3'b111);
    chk("rst_mid_busy", wr_busy, 1'b0);
    tick(2);
    reset = 0;
    tick(3);
    wait_pix();
    cpu_rd(9'h0AA);

    // back-to-back writes during active video
    rnd_on = 1;
    wait_pix();
    cpu_wr(9'h055, 8'($urandom));
    cpu_wr(9'h0AB, 8'($urandom));
    wait_pix();
    cpu_rd(9'h055);
    wait_pix();
    cpu_rd(9'h0AB);

    // read while a write to the same address is still buffered
    wait_pix();
    cpu_wr(9'h040, 8'h11);
    wait_pix();
    CPU_A = 9'h040; DCON_in = 8'hEE; pal_m[9'h040] = 8'hEE;
    nCS_PAL = 0; nMEWR = 0; nMERD = 0;
    tick(8);
    chk("rd_bypass", DCON_out, 8'hEE);
    nMEWR = 1; nMERD = 1; nCS_PAL = 1;
    tick(3);
    wait_pix();
    cpu_rd(9'h040);

    // random CPU traffic at random offsets behind the pixel enable
    for (int i = 0; i < 80; i++) begin
      int o;
      wait_pix();
      o = $urandom_range(0, 3);
      if (o > 0) tick(o);
      if ($urandom_range(0, 1) == 1) cpu_wr(9'($urandom), 8'($urandom));
      else                           cpu_rd(9'($urandom));
    end

    rnd_on = 0;
    wait_pix(); wait_pix(); wait_pix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
